// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: defaults, FSM states, error codes.
package program_loader_pkg;

  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // True while a frame is being received (idle timer is armed).
  function automatic logic frame_active(input state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle timer for the program loader: a down-counter reloaded on every
// accepted byte, decremented while enabled, with a terminal-count flag.
// Ports:
//   clk, reset   clock, async active-high reset
//   load         reload to TIMEOUT_CYCLES (byte accepted)
//   en           count down this cycle (frame in progress)
//   tc_c         combinational: the next idle edge is the timeout edge
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload wins over decrement; counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(TIMEOUT_CYCLES);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count of 1 means TIMEOUT_CYCLES-1 idle edges have already passed.
  assign tc_c = en && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= CNT_W'(TIMEOUT_CYCLES);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives framed bytes {SYNC, HDR, data..., CSUM} over
// valid/ready, writes the data into instruction memory and releases the CPU
// with a start address once the frame checksum (XOR of HDR and data) matches.
// Ports:
//   clk, reset          clock, async active-high reset
//   in_valid/in_data    input byte stream; in_ready low only in ERR
//   err_clear           pulse to leave ERR
//   mem_we/addr/wdata   instruction memory write port (1 cycle per byte)
//   cpu_hold            processor reset request
//   start_address       processor start address, valid when cpu_hold=0
//   load_done           pulse when a frame is loaded and verified
//   error/err_code      sticky error flag and cause
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned          ADDR_W         = ADDR_W_DEF,
  parameter int unsigned          DATA_W         = DATA_W_DEF,
  parameter logic [DATA_W-1:0]    SYNC_BYTE      = DATA_W'(SYNC_BYTE_DEF),
  parameter int unsigned          TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              err_clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] start_address,
  output logic              load_done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned HALF_W = DATA_W / 2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] cnt_m1_q, cnt_m1_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic              load_done_q, load_done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;

  logic accept;
  logic timeout_tc;

  assign accept = in_valid && in_ready_q;

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (frame_active(state_q)),
    .tc_c  (timeout_tc)
  );

  // Next-state and output computation.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_m1_d    = cnt_m1_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    start_d     = start_q;
    load_done_d = 1'b0;
    error_d     = error_q;
    err_code_d  = err_code_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d    = ST_HDR;
          cpu_hold_d = 1'b1;
        end
      end
      ST_HDR: begin
        if (accept) begin
          base_d   = ADDR_W'(in_data[DATA_W-1:HALF_W]);
          cnt_m1_d = ADDR_W'(in_data[HALF_W-1:0]);
          idx_d    = '0;
          xor_d    = in_data;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          // Address arithmetic wraps at the memory depth.
          mem_addr_d  = base_q + idx_q;
          mem_wdata_d = in_data;
          xor_d       = xor_q ^ in_data;
          if (idx_q == cnt_m1_q) begin
            state_d = ST_CSUM;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (in_data == xor_q) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
            start_d     = base_q;
            state_d     = ST_IDLE;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_CSUM;
            state_d    = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        if (err_clear) begin
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A byte accepted on the terminal cycle restarts the timer instead.
    if (timeout_tc && !accept && frame_active(state_q)) begin
      error_d    = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_ERR;
    end

    in_ready_d = (state_d != ST_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      cnt_m1_q    <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      start_q     <= '0;
      load_done_q <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_m1_q    <= cnt_m1_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      start_q     <= start_d;
      load_done_q <= load_done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign start_address = start_q;
  assign load_done     = load_done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;

endmodule
